alu_mdu: RTL and testbench

- Parametrised successor to the single-cycle CPU ALU. Adds unsigned variants, NOR, variable shifts and signed overflow detection.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- All results are registered. A valid/ready handshake lets the EX stage stall during multi-cycle operations.
- Sits in EX, fed by the decoded rs/rt operands and the R-type func field.

---
 rtl/alu_mdu.sv | 188 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
`timescale 1ns/1ps
// EX-stage ALU with an iterative multiply/divide unit and architectural HI/LO.
// Single-cycle ops return one cycle after acceptance; MULT/DIV variants take WIDTH+1 busy cycles.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rtdata,
    input  logic [5:0]       func,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_reg;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] opa_reg, acc_hi_reg, acc_lo_reg;
    logic             neg_q_reg, neg_r_reg, dzero_reg;
    logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
    logic             out_valid_reg, overflow_reg, illegal_reg;

    logic [WIDTH-1:0] add_sum, sub_diff, and_v, or_v, xor_v, nor_v;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf, alu_ill, is_mdu;

    assign add_sum  = rsdata + rtdata;
    assign sub_diff = rsdata - rtdata;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign and_v[gi] = rsdata[gi] & rtdata[gi];
        assign or_v[gi]  = rsdata[gi] | rtdata[gi];
        assign xor_v[gi] = rsdata[gi] ^ rtdata[gi];
        assign nor_v[gi] = ~(rsdata[gi] | rtdata[gi]);
    end

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_ill    = 1'b0;
        is_mdu     = 1'b0;
        case (func)
            6'b100000: begin
                alu_result = add_sum;
                alu_ovf    = (rsdata[WIDTH-1] == rtdata[WIDTH-1]) && (add_sum[WIDTH-1] != rsdata[WIDTH-1]);
            end
            6'b100010: begin
                alu_result = sub_diff;
                alu_ovf    = (rsdata[WIDTH-1] != rtdata[WIDTH-1]) && (sub_diff[WIDTH-1] != rsdata[WIDTH-1]);
            end
            6'b100001: alu_result = add_sum;
            6'b100011: alu_result = sub_diff;
            6'b100100: alu_result = and_v;
            6'b100101: alu_result = or_v;
            6'b100110: alu_result = xor_v;
            6'b100111: alu_result = nor_v;
            6'b101010: alu_result = {{(WIDTH-1){1'b0}}, $signed(rsdata) < $signed(rtdata)};
            6'b101011: alu_result = {{(WIDTH-1){1'b0}}, rsdata < rtdata};
            6'b000100: alu_result = rtdata << rsdata[SHW-1:0];
            6'b000110: alu_result = rtdata >> rsdata[SHW-1:0];
            6'b000111: alu_result = $signed(rtdata) >>> rsdata[SHW-1:0];
            6'b001010: alu_result = rsdata;
            6'b010000: alu_result = hi_reg;
            6'b010010: alu_result = lo_reg;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: is_mdu = 1'b1;
            default:   alu_ill = 1'b1;
        endcase
    end

    // Signed MDU ops iterate on magnitudes; func[0]=1 selects the unsigned variants.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = ~func[0] & rsdata[WIDTH-1];
    assign b_neg = ~func[0] & rtdata[WIDTH-1];
    assign a_mag = a_neg ? -rsdata : rsdata;
    assign b_mag = b_neg ? -rtdata : rtdata;

    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opa_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opa_reg};
    assign div_ge    = ~div_diff[WIDTH];

    always_comb begin
        step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        step_lo = {acc_lo_reg[WIDTH-2:0], div_ge};
        if (state_reg == S_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    // Sign correction folds into the last iteration so result can be registered with out_valid.
    always_comb begin
        prod_fix = neg_q_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (state_reg == S_DIV) begin
            fix_hi = neg_r_reg ? -step_hi : step_hi;
            fix_lo = dzero_reg ? '1 : (neg_q_reg ? -step_lo : step_lo);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            opa_reg       <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dzero_reg     <= 1'b0;
            result_reg    <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_mdu) begin
                            state_reg  <= func[1] ? S_DIV : S_MUL;
                            count_reg  <= '0;
                            neg_q_reg  <= a_neg ^ b_neg;
                            neg_r_reg  <= a_neg;
                            dzero_reg  <= (rtdata == '0);
                            opa_reg    <= func[1] ? b_mag : a_mag;
                            acc_hi_reg <= '0;
                            acc_lo_reg <= func[1] ? a_mag : b_mag;
                        end else begin
                            out_valid_reg <= 1'b1;
                            result_reg    <= alu_result;
                            overflow_reg  <= alu_ovf;
                            illegal_reg   <= alu_ill;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    count_reg <= count_reg + SHW'(1);
                    if (count_reg == SHW'(WIDTH-1)) begin
                        acc_hi_reg    <= fix_hi;
                        acc_lo_reg    <= fix_lo;
                        result_reg    <= fix_lo;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        acc_hi_reg <= step_hi;
                        acc_lo_reg <= step_lo;
                    end
                end
                default: begin
                    hi_reg    <= acc_hi_reg;
                    lo_reg    <= acc_lo_reg;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign illegal   = illegal_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;
endmodule

// File: tb/tb_alu_mdu.sv
`timescale 1ns/1ps
// Directed bench for alu_mdu: a 32-bit instance for the full op set and a 16-bit
// instance for the scaled multiply/divide cases, both driven from shared stimulus.
module tb_alu_mdu;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011, F_SLLV = 6'b000100, F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111, F_MOV  = 6'b001010, F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011, F_BAD = 6'b111111;

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, use16;
    logic [5:0]  func;
    logic [31:0] rs, rt;

    logic        rdy32, ov32, ovf32, ill32;
    logic [31:0] res32, hi32, lo32;
    logic        rdy16, ov16, ovf16, ill16;
    logic [15:0] res16, hi16, lo16;
    logic        iv32, iv16;

    logic        cur_ready, cur_out_valid, cur_ovf, cur_ill;
    logic [31:0] cur_result, cur_hi, cur_lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign iv32 = in_valid & ~use16;
    assign iv16 = in_valid & use16;

    assign cur_ready     = use16 ? rdy16 : rdy32;
    assign cur_out_valid = use16 ? ov16  : ov32;
    assign cur_ovf       = use16 ? ovf16 : ovf32;
    assign cur_ill       = use16 ? ill16 : ill32;
    assign cur_result    = use16 ? {16'h0, res16} : res32;
    assign cur_hi        = use16 ? {16'h0, hi16}  : hi32;
    assign cur_lo        = use16 ? {16'h0, lo16}  : lo32;

    alu_mdu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
        .rsdata(rs), .rtdata(rt), .func(func),
        .out_valid(ov32), .result(res32), .overflow(ovf32), .illegal(ill32),
        .hi(hi32), .lo(lo32)
    );

    alu_mdu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .rsdata(rs[15:0]), .rtdata(rt[15:0]), .func(func),
        .out_valid(ov16), .result(res16), .overflow(ovf16), .illegal(ill16),
        .hi(hi16), .lo(lo16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue1(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ovf, input logic exp_ill);
        @(negedge clk);
        func = f; rs = a; rt = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid"}, cur_out_valid, 1);
        check({name, "_result"}, cur_result, exp_res);
        check({name, "_ovf"}, cur_ovf, exp_ovf);
        check({name, "_ill"}, cur_ill, exp_ill);
        $display("txn %s func=%b rs=%h rt=%h result=%h ovf=%b ill=%b", name, f, a, b, cur_result, cur_ovf, cur_ill);
    endtask

    task automatic mdu_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int exp_lat;
        exp_lat = use16 ? 17 : 33;
        @(negedge clk);
        func = f; rs = a; rt = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        check({name, "_busy"}, cur_ready, 0);
        while (!cur_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, cur_result, exp_lo);
        check({name, "_done_busy"}, cur_ready, 0);
        $display("txn %s func=%b rs=%h rt=%h latency=%0d result=%h", name, f, a, b, lat, cur_result);
        @(negedge clk);
        check({name, "_hi"}, cur_hi, exp_hi);
        check({name, "_lo"}, cur_lo, exp_lo);
        check({name, "_ready"}, cur_ready, 1);
        check({name, "_pulse"}, cur_out_valid, 0);
    endtask

    vec_t vecs[18];

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{F_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{F_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        vecs[2]  = '{F_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[3]  = '{F_SUBU, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[5]  = '{F_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[6]  = '{F_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        vecs[7]  = '{F_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
        vecs[8]  = '{F_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[9]  = '{F_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{F_SRAV, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        vecs[11] = '{F_SRLV, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0};
        vecs[12] = '{F_SLLV, 32'h00000024, 32'h00000001, 32'h00000010, 1'b0, 1'b0};
        vecs[13] = '{F_MOV,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[14] = '{F_BAD,  32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        vecs[15] = '{F_ADD,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0};
        vecs[16] = '{F_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0};
        vecs[17] = '{F_MFLO, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; use16 = 1'b0; func = '0; rs = '0; rt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", cur_ready, 1);
        check("rst_valid", cur_out_valid, 0);
        check("rst_result", cur_result, 0);
        check("rst_ovf", cur_ovf, 0);
        check("rst_ill", cur_ill, 0);
        check("rst_hi", cur_hi, 0);
        check("rst_lo", cur_lo, 0);

        // Back-to-back single-cycle ops: one new vector every cycle.
        @(negedge clk);
        func = vecs[0].func; rs = vecs[0].rs; rt = vecs[0].rt; in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), cur_ready, 1);
            check($sformatf("vec%0d_valid", i), cur_out_valid, 1);
            check($sformatf("vec%0d_result", i), cur_result, vecs[i].res);
            check($sformatf("vec%0d_ovf", i), cur_ovf, vecs[i].ovf);
            check($sformatf("vec%0d_ill", i), cur_ill, vecs[i].ill);
            $display("txn vec%0d func=%b rs=%h rt=%h result=%h ovf=%b ill=%b",
                     i, vecs[i].func, vecs[i].rs, vecs[i].rt, cur_result, cur_ovf, cur_ill);
            if (i < 17) begin
                func = vecs[i+1].func; rs = vecs[i+1].rs; rt = vecs[i+1].rt;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_valid", cur_out_valid, 0);
        check("idle_ovf", cur_ovf, 0);
        check("idle_ill", cur_ill, 0);

        mdu_op("mult", F_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue1("mfhi", F_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        mdu_op("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        mdu_op("div", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        mdu_op("div_negdiv", F_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        mdu_op("divu_zero", F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        mdu_op("div_minneg", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        mdu_op("div_zero", F_DIV, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
        issue1("mflo", F_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Reset during the eleventh divide iteration aborts the op and clears HI/LO.
        @(negedge clk);
        func = F_DIVU; rs = 32'd100; rt = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", cur_ready, 1);
        check("abort_valid", cur_out_valid, 0);
        check("abort_hi", cur_hi, 0);
        check("abort_lo", cur_lo, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (cur_out_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        $display("txn abort divu rs=%h rt=%h pulses=%0d", 32'd100, 32'd3, pulses);

        // in_valid held high for the whole busy period must yield exactly one operation.
        @(negedge clk);
        func = F_MULTU; rs = 32'd5; rt = 32'd6; in_valid = 1'b1;
        lat = 0; pulses = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (cur_out_valid) begin
                pulses++;
                in_valid = 1'b0;
                break;
            end
        end
        check("hold_latency", lat, 33);
        repeat (40) begin
            @(negedge clk);
            if (cur_out_valid) pulses++;
        end
        check("hold_pulses", pulses, 1);
        check("hold_lo", cur_lo, 32'd30);
        check("hold_hi", cur_hi, 0);
        check("hold_ready", cur_ready, 1);
        $display("txn hold multu rs=%h rt=%h latency=%0d pulses=%0d", 32'd5, 32'd6, lat, pulses);

        use16 = 1'b1;
        issue1("w16_add", F_ADD, 32'h00007FFF, 32'h00000001, 32'h00008000, 1'b1, 1'b0);
        issue1("w16_bad", F_BAD, 32'h00001234, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
        mdu_op("w16_mult", F_MULT, 32'h0000FFFD, 32'h00000007, 32'h0000FFFF, 32'h0000FFEB);
        mdu_op("w16_multu", F_MULTU, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 32'h00000001);
        mdu_op("w16_div", F_DIV, 32'h0000FFF9, 32'h00000002, 32'h0000FFFF, 32'h0000FFFD);
        mdu_op("w16_divu_zero", F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'h0000FFFF);
        mdu_op("w16_div_minneg", F_DIV, 32'h00008000, 32'h0000FFFF, 32'h00000000, 32'h00008000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
